recv_alphabet: RTL and testbench

//  Receive side of the board's FTDI UART link: deserialises 8N1 bytes arriving on ftdi_txd and checks

---
 rtl/recv_alphabet_pkg.sv | 25 ++
 rtl/recv_alphabet_uart_rx.sv | 130 +++++++++++++
 rtl/recv_alphabet.sv | 85 ++++++++
 tb/tb_recv_alphabet.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/recv_alphabet_pkg.sv
// rtl/recv_alphabet_pkg.sv - shared types, ASCII constants and letter-sequence helpers
package recv_alphabet_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  // Successor in the cyclic 'A'..'Z' sequence
  function automatic logic [7:0] next_letter(input logic [7:0] c);
    return (c == ASCII_Z) ? ASCII_A : c + 8'd1;
  endfunction

  // After a mismatch, follow the received letter; anything else restarts at 'A'
  function automatic logic [7:0] resync_letter(input logic [7:0] c);
    return ((c >= ASCII_A) && (c <= ASCII_Z)) ? next_letter(c) : ASCII_A;
  endfunction

endpackage

// File: rtl/recv_alphabet_uart_rx.sv
// rtl/recv_alphabet_uart_rx.sv - 8N1 UART receiver with input synchroniser and break handling
module uart_rx
  import recv_alphabet_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk_25mhz,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_rx_meta;
  logic             r_rxs;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;

  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_valid_nxt;
  logic             w_frame_nxt;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // FSM, counters, shift register and registered output pulses
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_nxt;
    end
  end

  // Next-state: start is confirmed mid-bit, later bits are sampled one bit period apart
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_frame_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rxs) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          if (r_rxs) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rxs, r_shift[7:1]};
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt = '0;
          if (r_rxs) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_frame_nxt = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        w_cnt_nxt = '0;
        if (r_rxs) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/recv_alphabet.sv
// rtl/recv_alphabet.sv - UART 'A'..'Z' sequence checker top; LED_ERR_DISPLAY_EN selects error LEDs
module recv_alphabet
  import recv_alphabet_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int ERR_W        = 16
) (
  input  logic             clk_25mhz,
  input  logic             reset_n,
  input  logic             ftdi_txd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       led
);

  logic [7:0]       w_rx_data;
  logic             w_rx_valid;
  logic             w_frame_err;
  logic             w_err_sat;

  logic [7:0]       r_expected;
  logic             r_seq_err;
  logic [ERR_W-1:0] r_err_count;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_25mhz(clk_25mhz),
    .reset_n  (reset_n),
    .rx       (ftdi_txd),
    .data     (w_rx_data),
    .valid    (w_rx_valid),
    .frame_err(w_frame_err)
  );

  assign w_err_sat = (r_err_count == {ERR_W{1'b1}});

  // Sequence checker and saturating error counter; a framed-bad byte never reaches the checker
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_expected  <= ASCII_A;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_seq_err <= 1'b0;
      if (w_rx_valid) begin
        if (w_rx_data == r_expected) begin
          r_expected <= next_letter(r_expected);
        end else begin
          r_seq_err  <= 1'b1;
          r_expected <= resync_letter(w_rx_data);
          if (!w_err_sat) r_err_count <= r_err_count + ERR_W'(1);
        end
      end else if (w_frame_err && !w_err_sat) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

`ifdef LED_ERR_DISPLAY_EN
  logic r_frame_seen;

  // Sticky record of any framing error since reset
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n)         r_frame_seen <= 1'b0;
    else if (w_frame_err) r_frame_seen <= 1'b1;
  end

  assign led = {r_frame_seen, r_err_count[6:0]};
`else
  assign led = w_rx_data;
`endif

  assign rx_data   = w_rx_data;
  assign rx_valid  = w_rx_valid;
  assign frame_err = w_frame_err;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_recv_alphabet.sv
// tb/tb_recv_alphabet.sv - self-checking bench for recv_alphabet (either LED_ERR_DISPLAY_EN build)
module tb_recv_alphabet;

  localparam int BIT     = 25_000_000 / 115_200;
  localparam int ERR_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        txd = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        seq_err;
  logic [15:0] err_count;
  logic [7:0]  led;

  int n_checks = 0;
  int n_errors = 0;

  int mon_valid = 0, mon_seq = 0, mon_frame = 0, mon_both = 0;
  int s_valid, s_seq, s_frame;

  typedef struct {
    bit         do_rst;
    logic [7:0] data;
    int         stop_low;
    bit         v;
    bit         s;
    bit         f;
    int         err;
  } vec_t;

  vec_t tbl [12];

  recv_alphabet dut (
    .clk_25mhz(clk),
    .reset_n  (reset_n),
    .ftdi_txd (txd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .seq_err  (seq_err),
    .err_count(err_count),
    .led      (led)
  );

  always #20 clk = ~clk;

  // Count every cycle each pulse is high, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid)  mon_valid++;
    if (seq_err)   mon_seq++;
    if (frame_err) mon_frame++;
    if (seq_err && frame_err) mon_both++;
  end

  function automatic logic [7:0] led_model(input logic [7:0] last, input bit fs, input int err);
    bit use_err;
`ifdef LED_ERR_DISPLAY_EN
    use_err = 1'b1;
`else
    use_err = 1'b0;
`endif
    return use_err ? {fs, err[6:0]} : last;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic snapshot();
    s_valid = mon_valid;
    s_seq   = mon_seq;
    s_frame = mon_frame;
  endtask

  task automatic hold(input logic v, input int n);
    txd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    if (stop_low > 0) hold(1'b0, stop_low * BIT);
    else              hold(1'b1, BIT);
  endtask

  task automatic apply_reset();
    txd = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bit v, input logic [7:0] d, input bit s,
                             input bit f, input int err, input logic [7:0] led_exp);
    check({tag, "_valid"}, mon_valid - s_valid, v);
    check({tag, "_data"},  rx_data, d);
    check({tag, "_seq"},   mon_seq - s_seq, s);
    check({tag, "_frame"}, mon_frame - s_frame, f);
    check({tag, "_err"},   err_count, err);
    check({tag, "_led"},   led, led_exp);
  endtask

  initial begin
    logic [7:0] t_last;
    bit         t_fs;
    int         m_exp, m_err, stop_low, gap;
    logic [7:0] m_last, b, k;
    bit         m_fs, ev, es, ef;

    tbl[0]  = '{1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h42, 0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h43, 0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 8'h59, 0, 1'b1, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b0, 8'h5A, 0, 1'b1, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 8'h43, 0, 1'b1, 1'b1, 1'b0, 2};
    tbl[7]  = '{1'b0, 8'h44, 0, 1'b1, 1'b0, 1'b0, 2};
    tbl[8]  = '{1'b0, 8'h31, 0, 1'b1, 1'b1, 1'b0, 3};
    tbl[9]  = '{1'b0, 8'h41, 0, 1'b1, 1'b0, 1'b0, 3};
    tbl[10] = '{1'b0, 8'h42, 3, 1'b0, 1'b0, 1'b1, 4};
    tbl[11] = '{1'b0, 8'h42, 0, 1'b1, 1'b0, 1'b0, 4};

    // Reset state while reset_n is held low
    repeat (2) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_frame", frame_err, 0);
    check("rst_seq", seq_err, 0);
    check("rst_err", err_count, 0);
    check("rst_led", led, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed vectors
    t_last = 8'h00;
    t_fs   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_rst) begin
        apply_reset();
        t_last = 8'h00;
        t_fs   = 1'b0;
      end
      snapshot();
      send_frame(tbl[i].data, tbl[i].stop_low);
      if (tbl[i].v) t_last = tbl[i].data;
      if (tbl[i].f) t_fs = 1'b1;
      check_frame($sformatf("tbl%0d", i), tbl[i].v, t_last, tbl[i].s, tbl[i].f, tbl[i].err,
                  led_model(t_last, t_fs, tbl[i].err));
      hold(1'b1, 10);
    end

    // Randomised frames against the sequence model, with back-to-back spacing
    apply_reset();
    m_exp = 0; m_err = 0; m_last = 8'h00; m_fs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'(65 + m_exp);
        5, 6, 7:       b = 8'(65 + $urandom_range(0, 25));
        default:       b = 8'($urandom_range(0, 255));
      endcase
      stop_low = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (stop_low > 0) begin
        ev = 1'b0; es = 1'b0; ef = 1'b1; m_fs = 1'b1;
        if (m_err < ERR_MAX) m_err++;
      end else begin
        ev = 1'b1; ef = 1'b0; m_last = b;
        if (int'(b) == 65 + m_exp) begin
          es = 1'b0;
          m_exp = (m_exp + 1) % 26;
        end else begin
          es = 1'b1;
          if (m_err < ERR_MAX) m_err++;
          if (b >= 8'd65 && b <= 8'd90) m_exp = (int'(b) - 65 + 1) % 26;
          else                          m_exp = 0;
        end
      end
      snapshot();
      send_frame(b, stop_low);
      check_frame($sformatf("rnd%0d_%0h", i, b), ev, m_last, es, ef, m_err,
                  led_model(m_last, m_fs, m_err));
      gap = (stop_low > 0) ? 8 : int'($urandom_range(0, 4));
      hold(1'b1, gap);
    end

    // Reset asserted in the middle of data bit 4
    k = 8'h4B;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(k[i], BIT);
    hold(k[4], BIT / 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_seq", seq_err, 0);
    txd = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    snapshot();
    hold(1'b1, 300);
    check("post_rst_quiet", (mon_valid - s_valid) + (mon_frame - s_frame) + (mon_seq - s_seq), 0);

    // Short low glitch on the idle line must not produce any pulse
    snapshot();
    hold(1'b0, 50);
    hold(1'b1, 300);
    check("glitch_valid", mon_valid - s_valid, 0);
    check("glitch_frame", mon_frame - s_frame, 0);
    check("glitch_seq", mon_seq - s_seq, 0);

    // Receiver must be back in idle and accept a clean 'A'
    snapshot();
    send_frame(8'h41, 0);
    check_frame("after_glitch", 1'b1, 8'h41, 1'b0, 1'b0, 0, led_model(8'h41, 1'b0, 0));
    hold(1'b1, 10);

    check("no_coincident_err", mon_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
